// File: rtl/add_serial_pipe_if.sv
// rtl/add_serial_pipe_if.sv - start/done handshake and operand/result bundle for add_serial_pipe
interface add_serial_pipe_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, s, co, ovf, zero
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, s, co, ovf, zero
  );
endinterface

// File: rtl/add_serial_pipe.sv
// rtl/add_serial_pipe.sv - digit-serial add/subtract, DIGIT bits per clock with registered carry
module add_serial_pipe #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  add_serial_pipe_if.slave io_pipe
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_co;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_sum_nxt;
  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DIGIT-1:0] w_dsum;
  logic             w_dco;
  logic             w_msb_cin;
  logic             w_last;
  logic             w_accept;

  // FIN behaves like IDLE for start so back-to-back ops lose no extra cycle
  assign w_accept = (r_state != ST_RUN) && io_pipe.start;
  assign w_last   = (r_cnt == CW'(N - 1));

  always_comb begin
    w_da      = r_a[int'(r_cnt) * DIGIT +: DIGIT];
    w_db      = r_b[int'(r_cnt) * DIGIT +: DIGIT];
    {w_dco, w_dsum} = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_c};
    // carry into the digit's top bit recovered from its sum bit
    w_msb_cin = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_dsum[DIGIT-1];
    w_sum_nxt = r_sum;
    w_sum_nxt[int'(r_cnt) * DIGIT +: DIGIT] = w_dsum;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_s    <= '0;
      r_co   <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      // subtract is a + ~b + 1
      r_a   <= io_pipe.a;
      r_b   <= io_pipe.mode ? ~io_pipe.b : io_pipe.b;
      r_c   <= io_pipe.mode ? 1'b1 : io_pipe.cin;
      r_cnt <= '0;
      r_sum <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum <= w_sum_nxt;
      r_c   <= w_dco;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_s    <= w_sum_nxt;
        r_co   <= w_dco;
        r_ovf  <= w_msb_cin ^ w_dco;
        r_zero <= (w_sum_nxt == '0);
      end
    end
  end

  assign io_pipe.busy = (r_state == ST_RUN);
  assign io_pipe.done = (r_state == ST_FIN);
  assign io_pipe.s    = r_s;
  assign io_pipe.co   = r_co;
  assign io_pipe.ovf  = r_ovf;
  assign io_pipe.zero = r_zero;
endmodule

// File: tb/tb_add_serial_pipe.sv
// tb/tb_add_serial_pipe.sv - directed-vector bench for add_serial_pipe in three width/digit configurations
module tb_add_serial_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  add_serial_pipe_if #(.WIDTH(16)) if16 ();
  add_serial_pipe_if #(.WIDTH(8))  if8 ();
  add_serial_pipe_if #(.WIDTH(32)) if32 ();

  add_serial_pipe #(.WIDTH(16), .DIGIT(4))  u16 (.i_clk(clk), .i_rst_n(rst_n), .io_pipe(if16));
  add_serial_pipe #(.WIDTH(8),  .DIGIT(1))  u8  (.i_clk(clk), .i_rst_n(rst_n), .io_pipe(if8));
  add_serial_pipe #(.WIDTH(32), .DIGIT(32)) u32 (.i_clk(clk), .i_rst_n(rst_n), .io_pipe(if32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic md,
                       input logic [31:0] a, input logic [31:0] b, input logic ci);
    case (sel)
      0: begin if16.start = st; if16.mode = md; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = ci; end
      1: begin if8.start  = st; if8.mode  = md; if8.a  = a[7:0];  if8.b  = b[7:0];  if8.cin  = ci; end
      default: begin if32.start = st; if32.mode = md; if32.a = a; if32.b = b; if32.cin = ci; end
    endcase
  endtask

  task automatic sample(input int sel, output logic bz, output logic dn, output logic [31:0] s,
                        output logic co, output logic ov, output logic zr);
    case (sel)
      0: begin bz = if16.busy; dn = if16.done; s = {16'h0, if16.s}; co = if16.co; ov = if16.ovf; zr = if16.zero; end
      1: begin bz = if8.busy;  dn = if8.done;  s = {24'h0, if8.s};  co = if8.co;  ov = if8.ovf;  zr = if8.zero;  end
      default: begin bz = if32.busy; dn = if32.done; s = if32.s; co = if32.co; ov = if32.ovf; zr = if32.zero; end
    endcase
  endtask

  task automatic chk_cleared(input int sel, input string tag);
    logic bz, dn, co, ov, zr;
    logic [31:0] s;
    sample(sel, bz, dn, s, co, ov, zr);
    chk({tag, "_busy"}, 64'(bz), 64'd0);
    chk({tag, "_done"}, 64'(dn), 64'd0);
    chk({tag, "_s"},    64'(s),  64'd0);
    chk({tag, "_co"},   64'(co), 64'd0);
    chk({tag, "_ovf"},  64'(ov), 64'd0);
    chk({tag, "_zero"}, 64'(zr), 64'd0);
  endtask

  // one operation; poke re-asserts start with other operands during the first RUN cycle
  task automatic run_op(input int sel, input string tag, input logic md, input logic [31:0] a,
                        input logic [31:0] b, input logic ci, input bit poke, input int lat,
                        input logic [31:0] es, input logic eco, input logic eov);
    logic bz, dn, co, ov, zr;
    logic [31:0] s;
    int n;
    drive(sel, 1'b1, md, a, b, ci);
    tick;
    sample(sel, bz, dn, s, co, ov, zr);
    chk({tag, "_busy_run"}, 64'(bz), 64'd1);
    n = 0;
    if (poke) begin
      drive(sel, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      tick;
      n = 1;
    end
    drive(sel, 1'b0, ~md, ~a, ~b, ~ci);
    sample(sel, bz, dn, s, co, ov, zr);
    while (!dn && n < 64) begin
      tick;
      n++;
      sample(sel, bz, dn, s, co, ov, zr);
    end
    chk({tag, "_lat"},  64'(n),  64'(lat));
    chk({tag, "_s"},    64'(s),  64'(es));
    chk({tag, "_co"},   64'(co), 64'(eco));
    chk({tag, "_ovf"},  64'(ov), 64'(eov));
    chk({tag, "_zero"}, 64'(zr), 64'(es == 32'h0));
    chk({tag, "_busy_fin"}, 64'(bz), 64'd0);
    tick;
    sample(sel, bz, dn, s, co, ov, zr);
    chk({tag, "_done_pulse"}, 64'(dn), 64'd0);
    chk({tag, "_s_hold"}, 64'(s), 64'(es));
  endtask

  task automatic reset_mid(input int sel, input string tag);
    logic bz, dn, co, ov, zr;
    logic [31:0] s;
    bit seen;
    drive(sel, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0);
    tick;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick;
    rst_n = 1'b0;
    tick;
    chk_cleared(sel, tag);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      sample(sel, bz, dn, s, co, ov, zr);
      if (dn) seen = 1'b1;
    end
    chk({tag, "_no_done"}, 64'(seen), 64'd0);
  endtask

  task automatic back_to_back;
    logic bz, dn, co, ov, zr;
    logic [31:0] s;
    logic [15:0] va [3] = '{16'h0001, 16'h00FF, 16'h8000};
    logic [15:0] vb [3] = '{16'h0002, 16'h0001, 16'h8000};
    logic [15:0] vs [3] = '{16'h0003, 16'h0100, 16'h0000};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic        vo [3] = '{1'b0, 1'b0, 1'b1};
    drive(0, 1'b1, 1'b0, 32'(va[0]), 32'(vb[0]), 1'b0);
    tick;
    for (int j = 0; j < 3; j++) begin
      if (j < 2) drive(0, 1'b1, 1'b0, 32'(va[j+1]), 32'(vb[j+1]), 1'b0);
      else       drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int t = 1; t <= 4; t++) begin
        tick;
        sample(0, bz, dn, s, co, ov, zr);
        if (t < 4 && dn) chk($sformatf("b2b%0d_early_done", j), 64'(dn), 64'd0);
      end
      chk($sformatf("b2b%0d_done", j), 64'(dn), 64'd1);
      chk($sformatf("b2b%0d_s", j), 64'(s), 64'(vs[j]));
      chk($sformatf("b2b%0d_co", j), 64'(co), 64'(vc[j]));
      chk($sformatf("b2b%0d_ovf", j), 64'(ov), 64'(vo[j]));
      if (j < 2) tick;
    end
    tick;
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    tick;
    tick;
    chk_cleared(0, "rst16");
    chk_cleared(1, "rst8");
    chk_cleared(2, "rst32");
    rst_n = 1'b1;
    tick;

    run_op(0, "w16_add",    1'b0, 32'h1234, 32'h4321, 1'b0, 1'b0, 4, 32'h5555, 1'b0, 1'b0);
    run_op(0, "w16_wrap",   1'b0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 4, 32'h0000, 1'b1, 1'b0);
    run_op(0, "w16_cin",    1'b0, 32'hFFFF, 32'h0001, 1'b1, 1'b0, 4, 32'h0001, 1'b1, 1'b0);
    run_op(0, "w16_sub",    1'b1, 32'h0005, 32'h0007, 1'b1, 1'b0, 4, 32'hFFFE, 1'b0, 1'b0);
    run_op(0, "w16_subov",  1'b1, 32'h8000, 32'h0001, 1'b0, 1'b0, 4, 32'h7FFF, 1'b1, 1'b1);
    run_op(0, "w16_addov",  1'b0, 32'h7FFF, 32'h0001, 1'b0, 1'b1, 4, 32'h8000, 1'b0, 1'b1);
    back_to_back;
    run_op(0, "w16_pre",    1'b0, 32'h0F0F, 32'h0101, 1'b0, 1'b0, 4, 32'h1010, 1'b0, 1'b0);
    reset_mid(0, "w16_rstmid");

    run_op(1, "w8_add",     1'b0, 32'h12, 32'h34, 1'b0, 1'b0, 8, 32'h46, 1'b0, 1'b0);
    run_op(1, "w8_wrap",    1'b0, 32'hFF, 32'h01, 1'b0, 1'b0, 8, 32'h00, 1'b1, 1'b0);
    run_op(1, "w8_cin",     1'b0, 32'hFF, 32'h00, 1'b1, 1'b0, 8, 32'h00, 1'b1, 1'b0);
    run_op(1, "w8_sub",     1'b1, 32'h05, 32'h07, 1'b0, 1'b0, 8, 32'hFE, 1'b0, 1'b0);
    run_op(1, "w8_subov",   1'b1, 32'h80, 32'h01, 1'b0, 1'b0, 8, 32'h7F, 1'b1, 1'b1);
    run_op(1, "w8_addov",   1'b0, 32'h7F, 32'h01, 1'b0, 1'b1, 8, 32'h80, 1'b0, 1'b1);
    reset_mid(1, "w8_rstmid");

    run_op(2, "w32_add",    1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1, 32'hACF1_3568, 1'b0, 1'b0);
    run_op(2, "w32_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op(2, "w32_sub",    1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(2, "w32_subov",  1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op(2, "w32_addov",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1, 32'h8000_0001, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/add_serial_pipe.md
Name: add_serial_pipe

Overview:
- Parametrised, multi-cycle successor to the fixed 16-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a registered carry between digits.
- Provides a start/busy/done handshake, carry-in and status flags (carry, signed overflow, zero).
- Sits in the datapath where area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
clk    in   1      rising-edge clock
rst_n  in   1      synchronous reset, active-low
start  in   1      request; sampled only while busy=0
mode   in   1      0 = add (a+b+cin), 1 = subtract (a-b); sampled with start
a      in   WIDTH  operand A; sampled with start
b      in   WIDTH  operand B; sampled with start
cin    in   1      carry-in for add mode; ignored in subtract mode
busy   out  1      operation in progress
done   out  1      one-cycle pulse: result valid
s      out  WIDTH  result
co     out  1      carry-out of MSB; in subtract mode 1 = no borrow (a >= b unsigned)
ovf    out  1      two's-complement signed overflow
zero   out  1      1 when s == 0

Behaviour:
- Constant N = WIDTH/DIGIT is the number of digit steps.
- Reset: when rst_n=0 at a rising edge, all outputs go to 0 (busy, done, s, co, ovf, zero) and the FSM enters IDLE.
  - Reset wins over every other input.
  - Reset mid-operation aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 at edge k captures a, b, mode and cin into internal registers.
    - The capture uses b' = mode ? ~b : b and c0 = mode ? 1 : cin.
    - Digit counter is cleared; next state is RUN; busy=1 from edge k.
  - RUN: at each edge, digit i (bits i*DIGIT .. i*DIGIT+DIGIT-1) is added as a' + b' + c.
    - The sum digit is written into the result shift/position register and the carry register is updated.
    - After the edge that processes digit N-1 (edge k+N), next state is FIN.
  - FIN: lasts one cycle. During it done=1, busy=0, and s/co/ovf/zero are valid. Next state is IDLE.
    - start=1 during FIN is accepted exactly as in IDLE, so back-to-back operations have one idle-free gap.
- Latency: start sampled at edge k -> done high during the cycle following edge k+N.
  - Throughput is one result per N+1 cycles.
- s, co, ovf and zero are updated only on the transition into FIN. They hold their values until the next FIN or reset; they do not change during RUN.
- Flag rules:
  - co = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (s == 0).
- start=1 while busy=1 is ignored: no queuing, and operands in flight are unaffected.
- Changes to a, b, mode or cin after capture have no effect on the operation in flight.
- Wrap-around: the result is modulo 2^WIDTH, with no saturation.
- DIGIT = WIDTH gives N = 1: busy is high for one cycle, then FIN.
- The bit-level sum within a digit may use any combinational adder. Results must be bit-exact to (a + b + cin) mod 2^WIDTH, and to (a - b) mod 2^WIDTH in subtract mode.

Test Plan:
- WIDTH=16, DIGIT=4, reset then start with a=16'h1234, b=16'h4321, mode=0, cin=0 -> busy for 4 cycles; done pulse in the 5th cycle after the capture edge; s=16'h5555, co=0, ovf=0, zero=0.
- Add with carry: a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, co=1, ovf=0, zero=1. Repeat with cin=1 -> s=16'h0001, co=1.
- Subtract: a=16'h0005, b=16'h0007, mode=1 -> s=16'hFFFE, co=0 (borrow), ovf=0. Then a=16'h8000, b=16'h0001 -> s=16'h7FFF, co=1, ovf=1.
- Signed add overflow: a=16'h7FFF, b=16'h0001 -> s=16'h8000, ovf=1, co=0. Assert start again during busy with different operands -> ignored; result unchanged.
- Back-to-back: start held high continuously -> done pulses every 5 cycles; each result matches the operands sampled at its own capture edge.
- Reset mid-op: drive rst_n=0 during the 2nd RUN cycle -> next cycle all outputs are 0 and no done pulse appears. Also re-run the scenarios above with WIDTH=8, DIGIT=1 (8-cycle latency) and WIDTH=32, DIGIT=32 (1-cycle RUN).
